fifo_nibble_uart_tx: RTL and testbench

FIFO_NIBBLE_UART_TX -- requirements
Module: fifo_nibble_uart_tx

---
 rtl/fifo_nibble_uart_tx.sv | 178 +++++++++++++++++
 tb/tb_fifo_nibble_uart_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_nibble_uart_tx.sv
// ============================================================================
// Module      : fifo_nibble_uart_tx
// Description : Reads two nibbles from an upstream FIFO and sends the
//               assembled byte as a UART frame: start, 8 data bits LSB
//               first, optional even parity, stop. Define UART_PARITY_EN
//               to enable the parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fifo_nibble_uart_tx #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             empty,
    input  logic [WIDTH-1:0] rdata,
    output logic             rd_rq,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [7:0] C_LAST_TICK = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_REQ_LO  = 4'd1,
        S_CAP_LO  = 4'd2,
        S_WAIT_HI = 4'd3,
        S_REQ_HI  = 4'd4,
        S_CAP_HI  = 4'd5,
        S_START   = 4'd6,
        S_DATA    = 4'd7,
        S_PARITY  = 4'd8,
        S_STOP    = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] byte_q, byte_d;
    logic       tx_q, tx_d;
    logic       rd_rq_q, rd_rq_d;
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;

    logic       w_tick;

    assign w_tick = (baud_q == C_LAST_TICK);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;

        case (state_q)
            S_IDLE: begin
                if (!empty) state_d = S_REQ_LO;
            end
            S_REQ_LO: begin
                state_d = S_CAP_LO;
            end
            S_CAP_LO: begin
                byte_d[3:0] = rdata[3:0];
                state_d     = empty ? S_WAIT_HI : S_REQ_HI;
            end
            S_WAIT_HI: begin
                if (!empty) state_d = S_REQ_HI;
            end
            S_REQ_HI: begin
                state_d = S_CAP_HI;
            end
            S_CAP_HI: begin
                byte_d[7:4] = rdata[3:0];
                baud_d      = 8'd0;
                bit_d       = 3'd0;
                state_d     = S_START;
            end
            S_START: begin
                if (w_tick) begin
                    baud_d  = 8'd0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    baud_d = 8'd0;
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    baud_d  = 8'd0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    baud_d  = 8'd0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = 8'd0;
                bit_d   = 3'd0;
            end
        endcase

        // Outputs are decoded from the next state so they register cleanly
        rd_rq_d      = (state_d == S_REQ_LO) || (state_d == S_REQ_HI);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_STOP) && (baud_d == C_LAST_TICK);

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = byte_d[bit_d];
`ifdef UART_PARITY_EN
            S_PARITY: tx_d = ^byte_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            baud_q       <= 8'd0;
            bit_q        <= 3'd0;
            byte_q       <= 8'd0;
            tx_q         <= 1'b1;
            rd_rq_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            byte_q       <= byte_d;
            tx_q         <= tx_d;
            rd_rq_q      <= rd_rq_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx         = tx_q;
    assign rd_rq      = rd_rq_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_nibble_uart_tx.sv
// ============================================================================
// Module      : tb_fifo_nibble_uart_tx
// Description : Bench for fifo_nibble_uart_tx with a nibble FIFO model and a
//               frame-level reference built from the byte value.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_nibble_uart_tx;

    localparam int CPB = 8;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       empty;
    logic [3:0] rdata = 4'h0;
    logic       rd_rq;
    logic       tx;
    logic       busy;
    logic       frame_done;

    logic [3:0] mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       hold_empty = 1'b0;
    logic       prev_empty = 1'b1;
    int         rd_cnt  = 0;
    int         rd_viol = 0;
    int         fd_cnt  = 0;

    int n_cmp = 0;
    int n_err = 0;

    fifo_nibble_uart_tx #(
        .WIDTH        (4),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .empty      (empty),
        .rdata      (rdata),
        .rd_rq      (rd_rq),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    assign empty = hold_empty || (rd_ptr >= wr_ptr);

    // FIFO model: data appears on rdata the cycle after a read request
    always @(posedge clk) begin
        if (rd_rq === 1'b1) begin
            rd_cnt <= rd_cnt + 1;
            if (prev_empty || rd_ptr >= wr_ptr) begin
                rd_viol <= rd_viol + 1;
            end else begin
                rdata  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1;
            end
        end
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
        prev_empty <= empty;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] n);
        mem[wr_ptr] = n;
        wr_ptr++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference frame: index 0 is the start bit, last index is the stop bit
    function automatic logic [NB-1:0] frame_bits(input logic [7:0] b);
`ifdef UART_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    task automatic check_frame(input logic [7:0] b, input int exp_wait, input bit jitter);
        logic [NB-1:0] bits;
        int waited, good, ctl_bad, fd_pos, fd_hits;
        bits = frame_bits(b);
        waited = 0; ctl_bad = 0; fd_pos = -1; fd_hits = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (tx !== 1'b0 && waited < 400);
        chk($sformatf("start_latency_%02h", b), waited, exp_wait);
        if (tx !== 1'b0) return;
        for (int k = 0; k < NB; k++) begin
            good = 0;
            for (int c = 0; c < CPB; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                if (tx === bits[k]) good++;
                if (busy !== 1'b1 || rd_rq !== 1'b0) ctl_bad++;
                if (frame_done === 1'b1) begin
                    fd_hits++;
                    if (fd_pos < 0) fd_pos = k * CPB + c;
                end
                if (jitter) hold_empty = 1'($urandom_range(0, 1));
            end
            chk($sformatf("bit%0d_of_%02h", k, b), good, CPB);
        end
        hold_empty = 1'b0;
        chk("frame_ctl", ctl_bad, 0);
        chk("frame_cycles", fd_pos + 1, NB * CPB);
        chk("frame_done_hits", fd_hits, 1);
        @(negedge clk);
        chk("idle_tx_after_stop", int'(tx === 1'b1), 1);
    endtask

    initial begin
        logic [7:0] b;
        logic [3:0] nib [0:7];
        int bad, waited, r0, f0, g, ew;

        // Reset with data already waiting
        reset = 1'b1;
        push(4'h5);
        push(4'hA);
        repeat (2) begin
            @(negedge clk);
            chk("rst_tx", int'(tx === 1'b1), 1);
            chk("rst_rd_rq", int'(rd_rq === 1'b0), 1);
            chk("rst_busy", int'(busy === 1'b0), 1);
        end
        chk("rst_frame_done", int'(frame_done === 1'b0), 1);
        reset = 1'b0;

        check_frame(8'hA5, 5, 1'b0);
        chk("a5_reads", rd_cnt, 2);
        chk("a5_frames", fd_cnt, 1);

        push(4'h7);
        push(4'h0);
        check_frame(8'h07, 5, 1'b0);

        // Low nibble only, then a long dry spell before the high nibble
        push(4'h3);
        bad = 0;
        for (int j = 1; j <= 52; j++) begin
            @(negedge clk);
            if (j >= 3 && (tx !== 1'b1 || busy !== 1'b1 || rd_rq !== 1'b0)) bad++;
        end
        chk("wait_hi_hold", bad, 0);
        push(4'hC);
        check_frame(8'hC3, 3, 1'b0);

        // Reset in the middle of data bit 4
        b = 8'($urandom);
        push(b[3:0]);
        push(b[7:4]);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (tx !== 1'b0 && waited < 400);
        chk("mid_rst_start_latency", waited, 5);
        tick(43);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", int'(tx === 1'b1), 1);
        chk("mid_rst_busy", int'(busy === 1'b0), 1);
        chk("mid_rst_rd_rq", int'(rd_rq === 1'b0), 1);
        reset = 1'b0;
        r0 = rd_cnt;
        f0 = fd_cnt;
        tick(6);
        chk("post_rst_idle", int'(busy === 1'b0 && tx === 1'b1), 1);
        chk("post_rst_no_frame", fd_cnt - f0, 0);
        b = 8'($urandom);
        push(b[3:0]);
        push(b[7:4]);
        check_frame(b, 5, 1'b0);
        chk("post_rst_fresh_reads", rd_cnt - r0, 2);

        // Eight nibbles queued at once
        r0 = rd_cnt;
        f0 = fd_cnt;
        for (int i = 0; i < 8; i++) begin
            nib[i] = 4'($urandom);
            push(nib[i]);
        end
        for (int f = 0; f < 4; f++) begin
            if (f > 0) chk("stream_idle_gap", int'(busy === 1'b0), 1);
            check_frame({nib[2*f+1], nib[2*f]}, 5, 1'b1);
        end
        chk("stream_frames", fd_cnt - f0, 4);
        chk("stream_reads", rd_cnt - r0, 8);

        // Random bytes with random idle time and random nibble spacing
        for (int r = 0; r < 4; r++) begin
            b = 8'($urandom);
            tick($urandom_range(0, 4));
            g = $urandom_range(0, 6);
            push(b[3:0]);
            if (g > 0) tick(g);
            push(b[7:4]);
            ew = (g + 3 > 5) ? 3 : 5 - g;
            check_frame(b, ew, 1'b1);
        end

        chk("read_protocol_violations", rd_viol, 0);
        chk("total_reads", rd_cnt, wr_ptr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
